// File: rtl/control_sequencer_if.sv
// control_sequencer_if: IR opcode into the sequencer; T-state, halt and register bus strobes out of it (master = sequencer, slave = datapath)
interface control_sequencer_if;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       halt, pc_inc, pc_rd, mar_wr, ram_rd, ir_wr, ir_rd, a_wr, a_rd, b_wr, alu_rd, sub, out_wr;
  modport master (
    input  opcode,
    output t_state, halt, pc_inc, pc_rd, mar_wr, ram_rd, ir_wr, ir_rd, a_wr, a_rd, b_wr, alu_rd, sub, out_wr
  );
  modport slave (
    output opcode,
    input  t_state, halt, pc_inc, pc_rd, mar_wr, ram_rd, ir_wr, ir_rd, a_wr, a_rd, b_wr, alu_rd, sub, out_wr
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: falling-edge six-T-state microcode sequencer; ports clk, clr (async active-high reset), bus (master: opcode in, t_state/halt/strobes out)
module control_sequencer #(
  parameter logic [3:0] OPC_LDA = 4'b0000,
  parameter logic [3:0] OPC_ADD = 4'b0001,
  parameter logic [3:0] OPC_SUB = 4'b0010,
  parameter logic [3:0] OPC_OUT = 4'b1110,
  parameter logic [3:0] OPC_HLT = 4'b1111
) (
  input logic clk,
  input logic clr,
  control_sequencer_if.master bus
);
  typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALT} state_t;
  localparam int PC_INC = 11, PC_RD = 10, MAR_WR = 9, RAM_RD = 8, IR_WR = 7, IR_RD = 6;
  localparam int A_WR = 5, A_RD = 4, B_WR = 3, ALU_RD = 2, SUB_SEL = 1, OUT_WR = 0;
  state_t      state, nxt;
  logic [3:0]  op, op_nxt;
  logic        is_hlt;
  logic [18:0] outs;
  function automatic logic [18:0] decode(state_t s, logic [3:0] o);
    logic [11:0] c;
    c = '0;
    case (s)
      T1: begin c[PC_RD] = 1'b1; c[MAR_WR] = 1'b1; end
      T2: c[PC_INC] = 1'b1;
      T3: begin c[RAM_RD] = 1'b1; c[IR_WR] = 1'b1; end
      T4: case (o)
        OPC_LDA, OPC_ADD, OPC_SUB: begin c[IR_RD] = 1'b1; c[MAR_WR] = 1'b1; end
        OPC_OUT: begin c[A_RD] = 1'b1; c[OUT_WR] = 1'b1; end
        default: ;
      endcase
      T5: case (o)
        OPC_LDA: begin c[RAM_RD] = 1'b1; c[A_WR] = 1'b1; end
        OPC_ADD, OPC_SUB: begin c[RAM_RD] = 1'b1; c[B_WR] = 1'b1; c[SUB_SEL] = (o == OPC_SUB); end
        default: ;
      endcase
      T6: case (o)
        OPC_ADD, OPC_SUB: begin c[ALU_RD] = 1'b1; c[A_WR] = 1'b1; c[SUB_SEL] = (o == OPC_SUB); end
        default: ;
      endcase
      default: ;
    endcase
    return {s == HALT, s == HALT ? 6'b0 : 6'b1 << s, c};
  endfunction
  always_comb begin
    case (bus.opcode)
      OPC_HLT: is_hlt = 1'b1;
      default: is_hlt = 1'b0;
    endcase
    op_nxt = state == T3 ? bus.opcode : op;
    nxt = state == HALT ? HALT :
          state == T3   ? (is_hlt ? HALT : T4) :
          state == T6   ? T1 : state_t'(state + 3'd1);
  end
  always_ff @(negedge clk or posedge clr)
    if (clr) begin
      state <= T1;
      op    <= 4'b0;
      outs  <= decode(T1, 4'b0);
    end else begin
      state <= nxt;
      op    <= op_nxt;
      outs  <= decode(nxt, op_nxt);
    end
  assign {bus.halt, bus.t_state, bus.pc_inc, bus.pc_rd, bus.mar_wr, bus.ram_rd, bus.ir_wr, bus.ir_rd,
          bus.a_wr, bus.a_rd, bus.b_wr, bus.alu_rd, bus.sub, bus.out_wr} = outs;
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Control sequencer for the 8-bit bus CPU: ring-counter T-state machine plus microcode decoder.
- Generates the wr_en/rd_en strobes for every bus-attached 8-bit register (PC, MAR, RAM, IR, A, B, ALU, OUT) from the opcode held in the instruction register.
- Sits directly upstream of the registers and drives their load/drive controls.
- Six T-states per instruction; HLT freezes the machine until clr.

Parameters:
OPC_LDA, 4'b0000, opcode: load A from RAM[operand]
OPC_ADD, 4'b0001, opcode: A = A + RAM[operand]
OPC_SUB, 4'b0010, opcode: A = A - RAM[operand]
OPC_OUT, 4'b1110, opcode: copy A to output register
OPC_HLT, 4'b1111, opcode: halt

Ports:
clk  input  1  system clock; sequencer advances on falling edge
clr  input  1  asynchronous active-high reset
opcode  input  4  IR upper nibble (IR mem_out[7:4])
t_state  output  6  one-hot T-state, bit0=T1 .. bit5=T6; all zero when halted
halt  output  1  machine halted
pc_inc  output  1  program counter increment
pc_rd  output  1  PC drives bus
mar_wr  output  1  MAR loads from bus
ram_rd  output  1  RAM drives bus
ir_wr  output  1  IR loads from bus
ir_rd  output  1  IR operand nibble drives bus
a_wr  output  1  A loads from bus
a_rd  output  1  A drives bus
b_wr  output  1  B loads from bus
alu_rd  output  1  ALU result drives bus
sub  output  1  ALU subtract select
out_wr  output  1  output register loads from bus

Behaviour:
- One clock; reset is asynchronous and active-high.
- States: T1..T6 (one-hot) plus HALT.
- clr=1 forces T1 immediately, independent of clk. This also applies mid-instruction: the instruction is abandoned, with no further strobes for it.
- Reset values:
  - t_state=6'b000001, halt=0.
  - pc_rd=1, mar_wr=1 (the T1 word).
  - All other outputs 0.
- State advances only on the falling edge of clk, so control outputs are stable across the registers' rising-edge sampling. One T-state is one full clk period.
- Transitions:
  - T1->T2->T3.
  - T3->HALT if opcode==OPC_HLT, else T3->T4.
  - T4->T5->T6->T1.
  - HALT->HALT until clr.
- opcode is sampled at the falling edge ending T3, after IR loads on the T3 rising edge.
- Control outputs are a pure combinational decode of state and opcode (Moore per state). Microcode, with unlisted signals 0:
  - T1: pc_rd, mar_wr.
  - T2: pc_inc.
  - T3: ram_rd, ir_wr.
  - LDA: T4 ir_rd, mar_wr. T5 ram_rd, a_wr. T6 none.
  - ADD: T4 ir_rd, mar_wr. T5 ram_rd, b_wr. T6 alu_rd, a_wr.
  - SUB: as ADD, plus sub=1 in T5 and T6.
  - OUT: T4 a_rd, out_wr. T5 none. T6 none.
  - Any other opcode: T4-T6 all 0 (NOP), still takes 6 T-states.
- HALT: halt=1, t_state=0, all strobes 0. The held opcode is ignored.
- Invariant: at most one of {pc_rd, ram_rd, ir_rd, a_rd, alu_rd} is high in any state. This prevents bus contention.
- Invariant: pc_inc asserts exactly once per instruction.
- No X on any output after clr, for any opcode value including X/Z on unused encodings. An unknown opcode is decoded as NOP.

Test Plan:
- clr=1 asserted between clock edges -> t_state=000001, pc_rd=1, mar_wr=1 immediately, all other outputs 0. Hold clr for 3 cycles -> no change.
- opcode=0000 (LDA), release clr, sample each negedge+1 -> T1 {pc_rd,mar_wr}, T2 {pc_inc}, T3 {ram_rd,ir_wr}, T4 {ir_rd,mar_wr}, T5 {ram_rd,a_wr}, T6 {} -> next cycle t_state=000001.
- opcode=0010 (SUB) -> T5 {ram_rd,b_wr,sub}, T6 {alu_rd,a_wr,sub}. Same run with opcode=0001 -> sub=0 throughout.
- opcode=1110 (OUT) -> T4 {a_rd,out_wr}. opcode=0101 -> T4-T6 all strobes 0, cycle length still 6.
- opcode=1111 -> after T3: halt=1, t_state=000000, all strobes 0 for 10+ cycles. Then clr pulse -> T1 word, halt=0.
- ADD with clr pulsed during T5 -> T1 immediately, b_wr drops. Across all opcodes 0000-1111, every cycle: at most one *_rd high (checker asserts).
